// File: rtl/matmul_pkg.sv
// ----------------------------------------------------------------------------
// matmul_pkg
// Shared types and engine sizing for the matmul job scheduler.
//   sched_state_t : scheduler FSM states
//   A, B, C, BITS : default matmul_n engine geometry
//   ENG_LATENCY   : RUN cycles the default engine needs per job
// ----------------------------------------------------------------------------
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        REPORT
    } sched_state_t;

    localparam int A    = 16;
    localparam int B    = 32;
    localparam int C    = 24;
    localparam int BITS = 8;

    localparam int ENG_LATENCY = A * C * (B + 1);

endpackage

// File: rtl/matmul_job_sched_if.sv
// ----------------------------------------------------------------------------
// matmul_job_sched_if
// Requester-side job handshake and completion record of the scheduler.
//   req_valid   : per-requester job request
//   req_bank    : per-requester bank select, requester i at [i*BANK_W +: BANK_W]
//   req_ready   : one-hot grant/accept
//   done_valid  : completion record valid
//   done_ready  : completion record accept
//   done_id     : requester of the completed job
//   done_cycles : RUN cycles consumed
//   done_err    : job aborted by timeout
// Modports: master = requesters/consumer, slave = scheduler.
// ----------------------------------------------------------------------------
interface matmul_job_sched_if #(
    parameter int NREQ   = 2,
    parameter int BANK_W = 2,
    parameter int CYC_W  = 16
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*BANK_W-1:0] req_bank;
    logic [NREQ-1:0]        req_ready;

    logic                   done_valid;
    logic                   done_ready;
    logic [$clog2(NREQ)-1:0] done_id;
    logic [CYC_W-1:0]       done_cycles;
    logic                   done_err;

    modport master (
        output req_valid, req_bank, done_ready,
        input  req_ready, done_valid, done_id, done_cycles, done_err
    );

    modport slave (
        input  req_valid, req_bank, done_ready,
        output req_ready, done_valid, done_id, done_cycles, done_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter: grants the first asserted request found
// searching upward from ptr_i with wrap-around.
//   req_i   : request vector
//   ptr_i   : highest-priority index (must be < NREQ)
//   grant_o : one-hot grant, zero when no request
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = PW'((32'(ptr_i) + i) % NREQ);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/matmul_job_sched.sv
// ----------------------------------------------------------------------------
// matmul_job_sched
// Accepts multiply jobs from NREQ requesters (round-robin), resets the shared
// matmul engine to start each job, waits for its valid or a timeout, and
// reports completion with requester id, cycle count and error flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   job        : request/completion handshake (slave modport)
//   eng_rst    : engine synchronous reset, active-high
//   eng_valid  : engine result complete
//   eng_bank   : RAM bank set used by the current job
//   busy       : job in START/RUN/REPORT
// ----------------------------------------------------------------------------
module matmul_job_sched
    import matmul_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int BANK_W  = 2,
    parameter int CYC_W   = 16,
    parameter int TIMEOUT = 16384
) (
    input  logic               clk,
    input  logic               rst_n,
    matmul_job_sched_if.slave  job,
    output logic               eng_rst,
    input  logic               eng_valid,
    output logic [BANK_W-1:0]  eng_bank,
    output logic               busy
);

    localparam int IDW = $clog2(NREQ);

    sched_state_t     state_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   rr_ptr_d;
    logic [BANK_W-1:0] eng_bank_q;
    logic [CYC_W-1:0] cnt_q;
    logic [IDW-1:0]   done_id_q;
    logic [CYC_W-1:0] done_cycles_q;
    logic             done_err_q;
    logic             done_valid_q;
    logic             busy_q;
    logic             eng_rst_q;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_id;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i   (job.req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant)
    );

    always_comb begin
        grant_id = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) grant_id = i[IDW-1:0];
        end
    end

    assign rr_ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

    // Gated by rst_n so no grant is offered while reset is held.
    assign job.req_ready = (rst_n && state_q == IDLE) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            eng_bank_q    <= '0;
            cnt_q         <= '0;
            done_id_q     <= '0;
            done_cycles_q <= '0;
            done_err_q    <= 1'b0;
            done_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            eng_rst_q     <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|grant) begin
                        eng_bank_q <= job.req_bank[grant_id*BANK_W +: BANK_W];
                        done_id_q  <= grant_id;
                        rr_ptr_q   <= rr_ptr_d;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    // eng_rst stays high through this edge to reset the engine.
                    eng_rst_q <= 1'b0;
                    state_q   <= RUN;
                end
                RUN: begin
                    // Engine valid wins over a coincident timeout.
                    if (eng_valid) begin
                        done_cycles_q <= cnt_q;
                        done_err_q    <= 1'b0;
                        done_valid_q  <= 1'b1;
                        state_q       <= REPORT;
                    end else if (cnt_q == CYC_W'(TIMEOUT - 1)) begin
                        done_cycles_q <= CYC_W'(TIMEOUT);
                        done_err_q    <= 1'b1;
                        done_valid_q  <= 1'b1;
                        state_q       <= REPORT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                REPORT: begin
                    if (job.done_ready) begin
                        done_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        eng_rst_q    <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign eng_rst         = eng_rst_q;
    assign eng_bank        = eng_bank_q;
    assign busy            = busy_q;
    assign job.done_valid  = done_valid_q;
    assign job.done_id     = done_id_q;
    assign job.done_cycles = done_cycles_q;
    assign job.done_err    = done_err_q;

endmodule

// File: tb/tb_matmul_job_sched.sv
// ----------------------------------------------------------------------------
// tb_matmul_job_sched
// Scoreboard bench for matmul_job_sched with a behavioural engine whose
// latency (eng_lat) is set per job; TIMEOUT is reduced to 32.
// ----------------------------------------------------------------------------
module tb_matmul_job_sched;

    localparam int NREQ   = 2;
    localparam int BANK_W = 2;
    localparam int CYC_W  = 16;
    localparam int TO     = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              eng_rst;
    logic              eng_valid;
    logic              busy;
    logic [BANK_W-1:0] eng_bank;

    int checks = 0;
    int errors = 0;
    int eng_lat = 16;
    int n_pop = 0;
    int rr_m = 0;

    logic [15:0] ecnt;

    typedef struct {
        int id;
        int cyc;
        int err;
        int bank;
    } exp_t;

    exp_t sbq[$];

    matmul_job_sched_if #(.NREQ(NREQ), .BANK_W(BANK_W), .CYC_W(CYC_W)) job_if ();

    matmul_job_sched #(
        .NREQ    (NREQ),
        .BANK_W  (BANK_W),
        .CYC_W   (CYC_W),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .job       (job_if),
        .eng_rst   (eng_rst),
        .eng_valid (eng_valid),
        .eng_bank  (eng_bank),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Engine: synchronous reset, valid once eng_lat cycles have elapsed.
    always @(posedge clk) begin
        if (eng_rst) ecnt <= '0;
        else if (ecnt != '1) ecnt <= ecnt + 16'd1;
    end
    assign eng_valid = !eng_rst && (int'(ecnt) >= eng_lat);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_hs(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            smp();
            if (|(job_if.req_valid & job_if.req_ready)) seen = 1'b1;
        end
        chk(tag, 32'(seen), 1);
        if (seen) nxt();
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int n = 0; n < 400 && n_pop < target; n++) smp();
        chk(tag, 32'(n_pop >= target), 1);
    endtask

    // Scoreboard monitor: push on request handshake, pop on done handshake.
    initial begin : monitor
        int   g;
        exp_t e;
        logic [NREQ-1:0] oh;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sbq.delete();
                rr_m = 0;
            end else begin
                if (busy) chk("rdy_busy", 32'(job_if.req_ready), 0);
                if (|(job_if.req_valid & job_if.req_ready)) begin
                    g = -1;
                    for (int i = 0; i < NREQ; i++) begin
                        if (g < 0 && job_if.req_valid[(rr_m + i) % NREQ]) g = (rr_m + i) % NREQ;
                    end
                    oh = '0;
                    oh[g] = 1'b1;
                    chk("grant", 32'(job_if.req_ready), 32'(oh));
                    chk("hs_idle", 32'(busy), 0);
                    e.id   = g;
                    e.bank = int'(job_if.req_bank[g*BANK_W +: BANK_W]);
                    if (eng_lat <= TO - 1) begin
                        e.cyc = eng_lat;
                        e.err = 0;
                    end else begin
                        e.cyc = TO;
                        e.err = 1;
                    end
                    sbq.push_back(e);
                    rr_m = (g + 1) % NREQ;
                end
                if (job_if.done_valid && job_if.done_ready) begin
                    if (sbq.size() == 0) begin
                        chk("sb_empty", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("done_id", 32'(job_if.done_id), e.id);
                        chk("done_cycles", 32'(job_if.done_cycles), e.cyc);
                        chk("done_err", 32'(job_if.done_err), e.err);
                        chk("done_bank", 32'(eng_bank), e.bank);
                    end
                    n_pop++;
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n              = 1'b0;
        job_if.req_valid   = '1;
        job_if.req_bank    = '0;
        job_if.done_ready  = 1'b1;

        // Reset state and outputs while reset is held with requests pending.
        repeat (3) smp();
        chk("rst_ready", 32'(job_if.req_ready), 0);
        chk("rst_dvalid", 32'(job_if.done_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_engrst", 32'(eng_rst), 1);
        chk("rst_bank", 32'(eng_bank), 0);
        chk("rst_id", 32'(job_if.done_id), 0);
        chk("rst_cycles", 32'(job_if.done_cycles), 0);
        chk("rst_err", 32'(job_if.done_err), 0);
        nxt();
        job_if.req_valid = '0;
        rst_n = 1'b1;

        // Single job from requester 0, bank 2.
        nxt();
        job_if.req_bank  = {2'd0, 2'd2};
        job_if.req_valid = 2'b01;
        smp();
        chk("t1_ready", 32'(job_if.req_ready), 1);
        chk("t1_engrst_idle", 32'(eng_rst), 1);
        nxt();
        job_if.req_valid = '0;
        smp();
        chk("t1_engrst_start", 32'(eng_rst), 1);
        chk("t1_busy_start", 32'(busy), 1);
        chk("t1_bank_start", 32'(eng_bank), 2);
        chk("t1_ready_start", 32'(job_if.req_ready), 0);
        smp();
        chk("t1_engrst_run", 32'(eng_rst), 0);
        wait_done(1, "t1_done");
        chk("t1_engrst_report", 32'(eng_rst), 0);
        nxt();
        smp();
        chk("t1_bank_idle", 32'(eng_bank), 2);
        chk("t1_busy_idle", 32'(busy), 0);

        // Both requesters continuously valid: grants alternate over 4 jobs.
        nxt();
        job_if.req_bank  = {2'd1, 2'd3};
        job_if.req_valid = 2'b11;
        wait_done(5, "t2_done");
        nxt();
        job_if.req_valid = '0;

        // Backpressure on the completion record.
        job_if.done_ready = 1'b0;
        job_if.req_bank   = {2'd2, 2'd1};
        job_if.req_valid  = 2'b01;
        wait_hs("t3_hs");
        job_if.req_valid = 2'b11;
        for (int n = 0; n < 200 && !job_if.done_valid; n++) smp();
        chk("t3_dv_wait", 32'(job_if.done_valid), 1);
        for (int k = 0; k < 20; k++) begin
            chk("t3_dvalid", 32'(job_if.done_valid), 1);
            chk("t3_id", 32'(job_if.done_id), 0);
            chk("t3_cycles", 32'(job_if.done_cycles), 16);
            chk("t3_err", 32'(job_if.done_err), 0);
            chk("t3_ready", 32'(job_if.req_ready), 0);
            smp();
        end
        nxt();
        job_if.done_ready = 1'b1;
        wait_hs("t3_hs2");
        job_if.req_valid = '0;
        wait_done(7, "t3_done");

        // Timeout: engine never completes.
        nxt();
        eng_lat = 1000;
        job_if.req_valid = 2'b01;
        wait_hs("t4_hs");
        job_if.req_valid = '0;
        wait_done(8, "t4_done");

        // Engine valid coincides with the last allowed RUN cycle.
        nxt();
        eng_lat = TO - 1;
        job_if.req_valid = 2'b01;
        wait_hs("t5_hs");
        job_if.req_valid = '0;
        wait_done(9, "t5_done");

        // Reset asserted at RUN cycle 5 drops the job.
        nxt();
        eng_lat = 16;
        job_if.req_valid = 2'b01;
        wait_hs("t6_hs");
        job_if.req_valid = '0;
        repeat (6) smp();
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_dvalid", 32'(job_if.done_valid), 0);
        chk("t6_engrst", 32'(eng_rst), 1);
        chk("t6_bank", 32'(eng_bank), 0);
        nxt();
        nxt();
        rst_n = 1'b1;
        job_if.req_bank  = {2'd3, 2'd0};
        job_if.req_valid = 2'b10;
        smp();
        chk("t6_ready", 32'(job_if.req_ready), 2);
        nxt();
        job_if.req_valid = '0;
        wait_done(10, "t6_done");

        nxt();
        chk("sb_left", 32'(sbq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
